// File: rtl/alu_unit_pkg.sv
// Shared ALU constants: default datapath width and operation encodings.
package alu_unit_pkg;

  localparam int unsigned AluWidth = 32;
  localparam int unsigned ShamtW   = 5;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SRA = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu_comb.sv
// Purely combinational ALU datapath: A, B, op -> result.
module alu_comb
  import alu_unit_pkg::*;
#(
  parameter int unsigned WIDTH = AluWidth
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] result_o
);

  logic [ShamtW-1:0] shamt;

  // Only the low bits of B select the shift amount; upper bits are ignored.
  assign shamt = b_i[ShamtW-1:0];

  // Result select; every encoding is covered so no latch or X can appear.
  always_comb begin
    result_o = '0;
    unique case (alu_op_e'(op_i))
      ALU_AND: result_o = a_i & b_i;
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i + ~b_i + WIDTH'(1);
      ALU_OR:  result_o = a_i | b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_SLL: result_o = a_i << shamt;
      ALU_SRL: result_o = a_i >> shamt;
      ALU_SRA: result_o = WIDTH'($signed(a_i) >>> shamt);
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// Registered ALU: one-cycle latency result plus zero and sign flags.
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int unsigned WIDTH = AluWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUop,
  output logic [WIDTH-1:0] Output,
  output logic             zeroFlag,
  output logic             nFlag
);

  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] output_d, output_q;
  logic             zero_d, zero_q;
  logic             n_d, n_q;

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_alu_comb (
    .a_i      (A),
    .b_i      (B),
    .op_i     (ALUop),
    .result_o (result)
  );

  // Flags come from the same result that is registered, so they never lag Output.
  always_comb begin
    output_d = result;
    zero_d   = (result == '0);
    n_d      = result[WIDTH-1];
  end

  // Output register stage; synchronous reset gives the all-zero result and its flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      output_q <= '0;
      zero_q   <= 1'b1;
      n_q      <= 1'b0;
    end else begin
      output_q <= output_d;
      zero_q   <= zero_d;
      n_q      <= n_d;
    end
  end

  assign Output   = output_q;
  assign zeroFlag = zero_q;
  assign nFlag    = n_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed, table-driven bench for alu_unit with reset and latency sequences.
module tb_alu_unit;
  import alu_unit_pkg::*;

  localparam int unsigned W = 32;

  logic         clk;
  logic         reset;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   ALUop;
  logic [W-1:0] Output;
  logic         zeroFlag;
  logic         nFlag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] exp_out;
    logic         exp_z;
    logic         exp_n;
  } vec_t;

  vec_t vecs[$];

  alu_unit #(
    .WIDTH (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .ALUop    (ALUop),
    .Output   (Output),
    .zeroFlag (zeroFlag),
    .nFlag    (nFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [W-1:0] eo, input logic ez,
                           input logic en);
    check({name, ".out"}, Output, eo);
    check({name, ".z"}, W'(zeroFlag), W'(ez));
    check({name, ".n"}, W'(nFlag), W'(en));
  endtask

  task automatic add_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input logic [W-1:0] eo, input logic ez,
                         input logic en);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.op = op;
    v.exp_out = eo; v.exp_z = ez; v.exp_n = en;
    vecs.push_back(v);
  endtask

  initial begin
    logic [W-1:0] prev_out;
    logic         prev_z;
    logic         prev_n;

    add_vec("and_10_20",   32'd10,         32'd20,         ALU_AND, 32'h0000_0000, 1'b1, 1'b0);
    add_vec("add_30_20",   32'd30,         32'd20,         ALU_ADD, 32'd50,        1'b0, 1'b0);
    add_vec("add_wrap",    32'hFFFF_FFFF,  32'd1,          ALU_ADD, 32'h0000_0000, 1'b1, 1'b0);
    add_vec("add_ovf",     32'h7FFF_FFFF,  32'd1,          ALU_ADD, 32'h8000_0000, 1'b0, 1'b1);
    add_vec("sub_fff",     32'h0000_0FFF,  32'h0000_0F0F,  ALU_SUB, 32'h0000_00F0, 1'b0, 1'b0);
    add_vec("sub_neg",     32'd20,         32'd30,         ALU_SUB, 32'hFFFF_FFF6, 1'b0, 1'b1);
    add_vec("sub_eq",      32'd5,          32'd5,          ALU_SUB, 32'h0000_0000, 1'b1, 1'b0);
    add_vec("sll_4",       32'h8000_0001,  32'd4,          ALU_SLL, 32'h0000_0010, 1'b0, 1'b0);
    add_vec("srl_4",       32'h8000_0001,  32'd4,          ALU_SRL, 32'h0800_0000, 1'b0, 1'b0);
    add_vec("sra_4",       32'h8000_0001,  32'd4,          ALU_SRA, 32'hF800_0000, 1'b0, 1'b1);
    add_vec("sra_pos",     32'h7FFF_FFF0,  32'd4,          ALU_SRA, 32'h07FF_FFFF, 1'b0, 1'b0);
    add_vec("sll_amt0",    32'h8000_0001,  32'h20,         ALU_SLL, 32'h8000_0001, 1'b0, 1'b1);
    add_vec("srl_amt0",    32'h8000_0001,  32'h20,         ALU_SRL, 32'h8000_0001, 1'b0, 1'b1);
    add_vec("sra_amt0",    32'h8000_0001,  32'h20,         ALU_SRA, 32'h8000_0001, 1'b0, 1'b1);
    add_vec("sll_hi_ign",  32'h0000_0001,  32'hFFFF_FFE4,  ALU_SLL, 32'h0000_0010, 1'b0, 1'b0);
    add_vec("or_pat",      32'hF0F0_F0F0,  32'h0FF0_0FF0,  ALU_OR,  32'hFFF0_FFF0, 1'b0, 1'b1);
    add_vec("xor_pat",     32'hF0F0_F0F0,  32'h0FF0_0FF0,  ALU_XOR, 32'hFF00_FF00, 1'b0, 1'b1);
    add_vec("and_pat",     32'hF0F0_F0F0,  32'h0FF0_0FF0,  ALU_AND, 32'h00F0_00F0, 1'b0, 1'b0);

    // Reset with live ADD inputs: inputs in the reset cycle are discarded.
    reset = 1'b1;
    A = 32'd30; B = 32'd20; ALUop = ALU_ADD;
    repeat (2) @(posedge clk);
    #1 check_all("reset_state", 32'h0, 1'b1, 1'b0);

    // First valid result exactly one edge after reset goes low.
    @(negedge clk);
    reset = 1'b0;
    #1 check_all("reset_hold", 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1 check_all("post_reset", 32'd50, 1'b0, 1'b0);

    // Table: new inputs must not show before the edge, and must show right after it.
    prev_out = Output; prev_z = zeroFlag; prev_n = nFlag;
    foreach (vecs[i]) begin
      @(negedge clk);
      A = vecs[i].a; B = vecs[i].b; ALUop = vecs[i].op;
      #2 check_all({vecs[i].name, ".pre"}, prev_out, prev_z, prev_n);
      @(posedge clk);
      #1 check_all(vecs[i].name, vecs[i].exp_out, vecs[i].exp_z, vecs[i].exp_n);
      prev_out = vecs[i].exp_out; prev_z = vecs[i].exp_z; prev_n = vecs[i].exp_n;
    end

    // Mid-stream reset clears a nonzero negative result, then recovery is one cycle.
    @(negedge clk);
    A = 32'd20; B = 32'd30; ALUop = ALU_SUB;
    @(posedge clk);
    #1 check_all("mid_pre", 32'hFFFF_FFF6, 1'b0, 1'b1);
    @(negedge clk);
    A = 32'd30; B = 32'd20; ALUop = ALU_ADD;
    reset = 1'b1;
    @(posedge clk);
    #1 check_all("mid_reset", 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 check_all("mid_recover", 32'd50, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width in bits; all requirements below use WIDTH=32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 Port: A  input  WIDTH  first operand.
REQ-005 Port: B  input  WIDTH  second operand; B[4:0] is shift amount for shift ops.
REQ-006 Port: ALUop  input  3  operation select, encodings per REQ-010.
REQ-007 Port: Output  output  WIDTH  registered result.
REQ-008 Port: zeroFlag  output  1  registered; high when the registered Output is all zeros.
REQ-009 Port: nFlag  output  1  registered; equals Output[WIDTH-1] (sign of result).

Function
REQ-010 ALUop encodings: 0 ALU_AND A&B; 1 ALU_ADD A+B; 2 ALU_SUB A-B; 3 ALU_OR A|B; 4 ALU_XOR A^B; 5 ALU_SLL A<<B[4:0]; 6 ALU_SRL logical A>>B[4:0]; 7 ALU_SRA arithmetic A>>>B[4:0].
REQ-011 Latency exactly one cycle: A, B, ALUop sampled at edge N appear on Output/zeroFlag/nFlag after edge N, held until edge N+1.
REQ-012 Outputs update every cycle when not in reset; no enable, no handshake, no stall.
REQ-013 ADD and SUB are modulo 2^WIDTH; carry-out and overflow discarded, no saturation.
REQ-014 SUB computed as A + ~B + 1; result is two's complement.
REQ-015 Shift amount 0 returns A unchanged; bits B[31:5] ignored for shifts.
REQ-016 zeroFlag and nFlag are derived from the same result value registered into Output in the same edge; never from a stale or next result.
REQ-017 Combinational result logic is fully defined for all 8 ALUop values; no latches, no X propagation for known inputs.
REQ-018 Flags are pure functions of the result; operands do not affect flags directly.

Reset
REQ-019 When reset is high at a rising clk edge: Output = 0, zeroFlag = 1, nFlag = 0 (consistent with REQ-008/009).
REQ-020 Reset dominates: inputs sampled in a reset cycle are discarded; first valid result appears one cycle after the first edge with reset low.
REQ-021 Reset asserted mid-stream clears outputs at that edge regardless of prior result.

Structure
REQ-022 ALUop encoding constants (ALU_AND..ALU_SRA) and WIDTH default SHALL live in a shared constants package/include used by the ALU, decoder and benches.
REQ-023 One combinational sub-module alu_comb (A, B, ALUop -> result) is natural; alu_unit wraps it with the output/flag register stage.
REQ-024 Bench clock comes from the codebase clock generator block driving clk; period 10 time units.

Verification
REQ-025 AND: A=10, B=20, ALUop=0 -> next cycle Output=0, zeroFlag=1, nFlag=0.
REQ-026 ADD: A=30, B=20, ALUop=1 -> Output=50, zeroFlag=0, nFlag=0; ADD 0xFFFFFFFF+1 -> Output=0, zeroFlag=1 (wrap).
REQ-027 SUB: A=0x00000FFF, B=0x00000F0F, ALUop=2 -> Output=0x000000F0; SUB A=20, B=30 -> Output=0xFFFFFFF6, nFlag=1.
REQ-028 Shifts: A=0x80000001, B=4: SLL -> 0x00000010, SRL -> 0x08000000, SRA -> 0xF8000000 (nFlag=1); B=0x20 (amount 0) -> Output=A.
REQ-029 OR/XOR: A=0xF0F0F0F0, B=0x0FF00FF0 -> OR 0xFFF0FFF0, XOR 0xFF00FF00, nFlag=1.
REQ-030 Reset: drive ADD 30+20, assert reset for one edge -> Output=0, zeroFlag=1, nFlag=0; deassert -> correct result exactly one cycle later; latency checked every vector.
